// File: rtl/imu_sync_cond_pkg.sv
// Shared types and constants for the IMU data-ready conditioner.
package imu_sync_cond_pkg;

    // Default fabric ticks per microsecond (125 MHz clock).
    localparam int TICKS_PER_USEC = 125;

    // Edge qualifier states.
    typedef enum logic [1:0] {
        WAIT_LO = 2'd0,
        ARMED   = 2'd1,
        QUAL_HI = 2'd2,
        HIGH    = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/imu_sync_cond_if.sv
// Control/status bundle between the IMU conditioner and its host/trigger logic.
interface imu_sync_cond_if;
    import imu_sync_cond_pkg::*;

    logic        en;
    logic        drdy_in;
    logic [15:0] timeout_usec;
    logic        timeout_clr;
    logic        imu_sync;
    logic [15:0] period_usec;
    logic        period_dv;
    logic        timeout;
    logic [15:0] pulse_cnt;

    modport master (
        output en, drdy_in, timeout_usec, timeout_clr,
        input  imu_sync, period_usec, period_dv, timeout, pulse_cnt
    );

    modport slave (
        input  en, drdy_in, timeout_usec, timeout_clr,
        output imu_sync, period_usec, period_dv, timeout, pulse_cnt
    );

endinterface

// File: rtl/imu_sync_cond_usec_tick.sv
// Free-running microsecond divider; tick marks the last count of each usec.
module usec_tick
    import imu_sync_cond_pkg::*;
#(
    parameter int TICKS = TICKS_PER_USEC
) (
    input  logic c,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             W  = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0]   TC = W'(TICKS - 1);

    logic [W-1:0] div_q;

    assign tick = en && (div_q == TC);

    // Divider counts 0..TICKS-1, held at 0 while disabled or cleared.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (!en || clr || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + W'(1);
        end
    end

endmodule

// File: rtl/imu_sync_cond.sv
// IMU data-ready conditioner: synchronizes and glitch-filters drdy_in,
// emits one imu_sync pulse per qualified rising edge, measures the edge
// period in usec and raises a sticky missing-IMU timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WAIT_LO | counting consecutive low cycles before re-arming
// ARMED   | low qualified, waiting for the pin to go high
// QUAL_HI | counting consecutive high cycles; a low drops back to ARMED
// HIGH    | edge accepted and pulsed, waiting for the pin to fall
module imu_sync_cond
    import imu_sync_cond_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_HI_CYC     = 16,
    parameter int MIN_LO_CYC     = 16,
    parameter int TICKS_PER_USEC = imu_sync_cond_pkg::TICKS_PER_USEC
) (
    input  logic           c,
    input  logic           rst,
    imu_sync_cond_if.slave bus
);

    localparam logic [7:0] HI_TC = 8'(MIN_HI_CYC);
    localparam logic [7:0] LO_TC = 8'(MIN_LO_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pulse_d;

    logic        tick;
    logic [15:0] usec_q;
    logic [15:0] usec_inc;
    logic        prev_valid_q;
    logic        timeout_set;

    logic        imu_sync_q;
    logic [15:0] period_usec_q;
    logic        period_dv_q;
    logic        timeout_q;
    logic [15:0] pulse_cnt_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability synchronizer; the only consumer of the raw pin.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.drdy_in};
        end
    end

    // Qualifier state and run-length counter.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; pulse_d is the edge-accept strobe registered into imu_sync.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!bus.en) begin
            state_d = WAIT_LO;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LO: begin
                    if (s) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == LO_TC) begin
                            state_d = ARMED;
                            cnt_d   = '0;
                        end
                    end
                end
                ARMED: begin
                    if (s) begin
                        state_d = QUAL_HI;
                        cnt_d   = 8'd1;
                    end
                end
                QUAL_HI: begin
                    if (!s) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == HI_TC) begin
                            state_d = HIGH;
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    usec_tick #(
        .TICKS (TICKS_PER_USEC)
    ) u_usec_tick (
        .c    (c),
        .rst  (rst),
        .en   (bus.en),
        .clr  (pulse_d),
        .tick (tick)
    );

    // A tick landing on the accept edge is folded into the captured period,
    // so an exact multiple of a usec reads back exactly.
    assign usec_inc    = sat_inc16(usec_q);
    assign timeout_set = tick && prev_valid_q && (bus.timeout_usec != 16'd0)
                         && (usec_inc != usec_q) && (usec_inc == bus.timeout_usec);

    // Elapsed usec since the last accepted edge, saturating.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            usec_q <= '0;
        end else if (!bus.en || pulse_d) begin
            usec_q <= '0;
        end else if (tick) begin
            usec_q <= usec_inc;
        end
    end

    // Tracks whether a previous edge exists to measure from.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            prev_valid_q <= 1'b0;
        end else if (!bus.en) begin
            prev_valid_q <= 1'b0;
        end else if (pulse_d) begin
            prev_valid_q <= 1'b1;
        end
    end

    // Output pulse, period capture, sticky timeout and pulse counter.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            imu_sync_q    <= 1'b0;
            period_usec_q <= '0;
            period_dv_q   <= 1'b0;
            timeout_q     <= 1'b0;
            pulse_cnt_q   <= '0;
        end else begin
            imu_sync_q  <= pulse_d;
            period_dv_q <= pulse_d && prev_valid_q;
            if (pulse_d && prev_valid_q) begin
                period_usec_q <= tick ? usec_inc : usec_q;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (bus.timeout_clr) begin
                timeout_q <= 1'b0;
            end
            if (pulse_d) begin
                pulse_cnt_q <= pulse_cnt_q + 16'd1;
            end
        end
    end

    assign bus.imu_sync    = imu_sync_q;
    assign bus.period_usec = period_usec_q;
    assign bus.period_dv   = period_dv_q;
    assign bus.timeout     = timeout_q;
    assign bus.pulse_cnt   = pulse_cnt_q;

endmodule

// File: tb/tb_imu_sync_cond.sv
// Scoreboard bench for imu_sync_cond: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever imu_sync is seen.
module tb_imu_sync_cond;

    localparam int TPU     = 5;
    localparam int LATENCY = 2 + 16;

    typedef struct {
        int          cyc;
        bit          dv;
        int          per;
        logic [15:0] cnt;
    } exp_t;

    logic c   = 1'b0;
    logic rst = 1'b1;

    imu_sync_cond_if bus ();

    imu_sync_cond #(
        .SYNC_STAGES    (2),
        .MIN_HI_CYC     (16),
        .MIN_LO_CYC     (16),
        .TICKS_PER_USEC (TPU)
    ) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    always #4 c = ~c;

    int cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    int   last_rise  = 0;
    bit   prev_valid = 1'b0;
    int   exp_cnt    = 0;
    int   rr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp);
        int d;
        checks++;
        d = act - exp;
        if (d > 1 || d < -1) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d+-1 (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every imu_sync must match the head of the scoreboard.
    always @(negedge c) begin
        if (bus.imu_sync === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("period_dv", int'(bus.period_dv), int'(mon_e.dv));
                if (mon_e.dv) chk_tol("period_usec", int'(bus.period_usec), mon_e.per);
                chk("pulse_cnt", int'(bus.pulse_cnt), int'(mon_e.cnt));
            end
        end else if (bus.period_dv === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL stray_period_dv actual=1 expected=0 (cycle %0d)", cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge c);
        #1;
    endtask

    // Raise the pin and record the pulse this rise must produce.
    task automatic edge_start();
        exp_t e;
        int   p;
        bus.drdy_in = 1'b1;
        exp_cnt     = (exp_cnt + 1) & 16'hFFFF;
        p           = (cyc - last_rise) / TPU;
        e.cyc       = cyc + LATENCY;
        e.dv        = prev_valid;
        e.per       = (p > 65535) ? 65535 : p;
        e.cnt       = 16'(exp_cnt);
        sb.push_back(e);
        prev_valid  = 1'b1;
        last_rise   = cyc;
    endtask

    task automatic edge_cycle(input int hi, input int total);
        edge_start();
        step(hi);
        bus.drdy_in = 1'b0;
        step(total - hi);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_imu_sync"},    int'(bus.imu_sync),    0);
        chk({tag, "_period_usec"}, int'(bus.period_usec), 0);
        chk({tag, "_period_dv"},   int'(bus.period_dv),   0);
        chk({tag, "_timeout"},     int'(bus.timeout),     0);
        chk({tag, "_pulse_cnt"},   int'(bus.pulse_cnt),   0);
    endtask

    initial begin
        bus.en           = 1'b0;
        bus.drdy_in      = 1'b0;
        bus.timeout_usec = 16'd0;
        bus.timeout_clr  = 1'b0;
        step(3);
        chk_all_zero("reset");
        rst    = 1'b0;
        bus.en = 1'b1;
        step(100);

        // 15-cycle highs never qualify.
        for (int i = 0; i < 5; i++) begin
            bus.drdy_in = 1'b1;
            step(15);
            bus.drdy_in = 1'b0;
            step(40);
        end
        chk("glitch_pulse_cnt", int'(bus.pulse_cnt), 0);
        step(60);

        // Clean edge (no period_dv) then steady 100 usec and one 60 usec period.
        edge_cycle(50, 500);
        chk("clean_pulse_cnt", int'(bus.pulse_cnt), 1);
        for (int i = 0; i < 3; i++) edge_cycle(20, 500);
        edge_cycle(20, 300);
        edge_cycle(20, 500);

        // Timeout 150 usec: no trip at 100 usec spacing, trips 750 cycles after the last pulse.
        bus.timeout_usec = 16'd150;
        edge_cycle(20, 500);
        edge_cycle(20, 500);
        edge_start();
        rr = cyc;
        step(20);
        bus.drdy_in = 1'b0;
        step(rr + LATENCY + 749 - cyc);
        chk("timeout_early", int'(bus.timeout), 0);
        step(1);
        chk("timeout_set", int'(bus.timeout), 1);

        // Pulse coinciding with timeout_clr leaves the flag clear.
        step(last_rise + 1000 - cyc);
        edge_start();
        rr = cyc;
        step(LATENCY - 1);
        bus.timeout_clr = 1'b1;
        step(1);
        bus.timeout_clr = 1'b0;
        chk("timeout_clr_with_pulse", int'(bus.timeout), 0);
        step(2);
        bus.drdy_in = 1'b0;
        step(100);
        chk("timeout_stays_clear", int'(bus.timeout), 0);

        // Set and clear in the same cycle resolve as set.
        step(rr + LATENCY + 749 - cyc);
        bus.timeout_clr = 1'b1;
        step(1);
        bus.timeout_clr = 1'b0;
        chk("timeout_set_beats_clr", int'(bus.timeout), 1);
        bus.timeout_clr = 1'b1;
        step(1);
        bus.timeout_clr = 1'b0;
        chk("timeout_cleared", int'(bus.timeout), 0);
        bus.timeout_usec = 16'd0;
        step(50);

        // en dropped mid-qualification, raised with pin high: no partial edge.
        bus.drdy_in = 1'b1;
        step(10);
        bus.en = 1'b0;
        prev_valid = 1'b0;
        step(5);
        chk("en_pulse_cnt_hold", int'(bus.pulse_cnt), exp_cnt);
        bus.en = 1'b1;
        step(40);
        bus.drdy_in = 1'b0;
        step(30);
        edge_cycle(20, 80);

        // Async reset while in HIGH clears every output between edges.
        edge_start();
        step(25);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        sb.delete();
        exp_cnt    = 0;
        prev_valid = 1'b0;
        step(2);
        rst = 1'b0;
        step(40);
        bus.drdy_in = 1'b0;
        step(30);

        // Reset during qualification discards the edge.
        bus.drdy_in = 1'b1;
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(40);
        chk("inflight_discard_cnt", int'(bus.pulse_cnt), 0);
        bus.drdy_in = 1'b0;
        step(30);
        edge_cycle(20, 80);

        step(20);
        chk("scoreboard_empty", sb.size(), 0);
        chk("final_pulse_cnt", int'(bus.pulse_cnt), exp_cnt);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imu_sync_cond.md
Name: imu_sync_cond

Overview:
- Conditions the raw IMU data-ready pin into the clean single-cycle `imu_sync` pulse consumed by the camera trigger generator.
- Synchronizes the asynchronous pin and glitch-filters it in both directions.
- Emits exactly one pulse per qualified rising edge.
- Measures the IMU period in microseconds and flags a missing IMU (timeout) for host firmware.
- Runs in the 125 MHz fabric clock domain, between the IMU pin and the trigger logic.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on `drdy_in`; legal values 2..4.
- MIN_HI_CYC, 16: consecutive synchronized-high cycles required to qualify an edge; legal values 2..255.
- MIN_LO_CYC, 16: consecutive synchronized-low cycles required to re-arm; legal values 2..255.
- TICKS_PER_USEC, 125: clock ticks per microsecond.

Ports:
- c  in  1  fabric clock, 125 MHz.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  conditioning enable.
- drdy_in  in  1  raw IMU data-ready pin; asynchronous, active-high.
- timeout_usec  in  16  missing-IMU threshold in usec; 0 disables the timeout.
- timeout_clr  in  1  single-cycle clear of the sticky timeout flag.
- imu_sync  out  1  single-cycle pulse per qualified rising edge.
- period_usec  out  16  last measured edge-to-edge period, saturating.
- period_dv  out  1  single-cycle strobe; `period_usec` updated this cycle.
- timeout  out  1  sticky missing-IMU flag.
- pulse_cnt  out  16  count of qualified pulses; wraps.

Behaviour:
- Reset and clock:
  - Reset is asynchronous and active-high on `rst`; single clock `c`.
  - All outputs reset to 0.
  - FSM resets to WAIT_LO.
  - All synchronizer flops, the usec divider and all counters reset to 0.
- Synchronizer: `drdy_in` passes through SYNC_STAGES flops; `s` is the last stage. Nothing else samples `drdy_in`.
- FSM states:
  - WAIT_LO:
    - Count consecutive `s==0` cycles.
    - On reaching MIN_LO_CYC, go to ARMED.
    - `s==1` resets the count.
  - ARMED: `s==1` goes to QUAL_HI with the count set to 1.
  - QUAL_HI:
    - `s==1` increments the count.
    - When the count reaches MIN_HI_CYC, go to HIGH and register `imu_sync`=1 for one cycle.
    - `s==0` before that returns to ARMED (glitch rejected, no pulse).
  - HIGH: `s==0` goes to WAIT_LO with the count set to 1.
- Latency: `imu_sync` is high on exactly clock edge SYNC_STAGES+MIN_HI_CYC, counting the first edge that samples `drdy_in`=1 as edge 1. The pulse is exactly one cycle wide.
- Enable:
  - `en`=0 forces the FSM to WAIT_LO and clears the usec divider and usec counter.
  - `imu_sync`/`period_dv` stay 0; `pulse_cnt` and `timeout` hold.
  - Re-enabling while the pin is already high yields no pulse until a full low qualification has occurred, so there are no partial edges.
- usec timebase:
  - Divider counts 0..TICKS_PER_USEC-1 and wraps.
  - The tick is the cycle where the divider equals TICKS_PER_USEC-1.
  - The 16-bit usec counter increments on each tick and saturates at 16'hFFFF.
- Period measurement:
  - On an `imu_sync` cycle with a valid previous edge: `period_usec` <= usec counter, and `period_dv`=1 in the same cycle.
  - On every `imu_sync` cycle, the usec counter and divider are cleared to 0.
  - First pulse after reset or after `en` rises: no `period_dv`; it only sets the valid-previous-edge flag.
  - `en`=0 clears that flag.
- Timeout:
  - With `timeout_usec`!=0, `timeout` sets on the tick at which the usec counter reaches `timeout_usec` after a previous edge exists.
  - `timeout` is sticky until `timeout_clr`; a set and a clear in the same cycle resolve as set.
  - A timed-out IMU's next pulse still produces `period_dv` with the saturated or true count.
- `pulse_cnt`: increments on each `imu_sync` and wraps 16'hFFFF to 0.
- Reset mid-operation: asynchronous return to the reset state; an in-flight qualification is discarded with no pulse.

Decomposition:
- Shared package:
  - FSM state enum: WAIT_LO, ARMED, QUAL_HI, HIGH.
  - Constant TICKS_PER_USEC=125.
- Sub-module `usec_tick`: the free-running divider, with `clr` and `en` inputs and a `tick` output. It is reusable by the trigger generator.

Test Plan:
- Clean edge: MIN_HI_CYC=16, `drdy_in` held low for 100 cycles, then high for 50 -> one `imu_sync` at edge 18 after the rise. `pulse_cnt`=1, no `period_dv`.
- Glitch rejection: high pulses of 15 cycles, repeated 5 times with 40 low cycles between -> zero `imu_sync`, `pulse_cnt`=0.
- Period measurement: 200 Hz input (625000 cycles), 20-cycle high pulses -> second and subsequent pulses give `period_dv` with `period_usec`=5000, ±1 for phase.
- Timeout: `timeout_usec`=6000, input stopped after 3 pulses -> `timeout`=1 at 6000 usec after the last pulse. A pulse arriving together with `timeout_clr` -> `timeout` stays 0 afterwards. `timeout_clr` asserted in the same cycle as the set -> `timeout`=1.
- Enable gating: `en` dropped mid-QUAL_HI, then raised while the pin is high -> no pulse until the pin has been low for 16 cycles and then high again. The first pulse after that has no `period_dv`.
- Async reset: `rst` asserted in HIGH between clock edges -> all outputs are 0 immediately. The next edge qualifies only after a low re-arm.
